// File: rtl/cell3_bist.sv
// cell3_bist: exhaustive 8-pattern self-test of a 3-input cell against a truth table.
// Each pattern is applied, allowed to settle for SETTLE cycles, then sampled once.
module cell3_bist #(
    parameter int         SETTLE = 10,
    parameter logic [7:0] TT     = 8'hFE
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       start,
    input  logic       ZN,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_vec
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;
    state_t     r_state;
    logic [2:0] r_idx;
    logic [2:0] r_a;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err;
    logic [7:0] r_fail;
    logic       w_mis;
    logic [3:0] w_err;

    // Case inequality so an undriven or unknown response counts as a failure.
    assign w_mis = (ZN !== TT[r_idx]);
    assign w_err = r_err + {3'b000, w_mis};

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= APPLY;
                        r_idx   <= '0;
                        r_a     <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_fail  <= '0;
                    end
                end
                APPLY: begin
                    r_cnt   <= 8'(SETTLE - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == 8'd0) r_state <= SAMPLE;
                    else r_cnt <= r_cnt - 8'd1;
                end
                SAMPLE: begin
                    r_err <= w_err;
                    if (w_mis) r_fail[r_idx] <= 1'b1;
                    if (r_idx == 3'd7) begin
                        r_state <= DONE;
                        r_a     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err == 4'd0);
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_a     <= r_idx + 3'd1;
                        r_state <= APPLY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign {A1, A2, A3} = r_a;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_cnt      = r_err;
    assign fail_vec     = r_fail;
endmodule

// File: tb/tb_cell3_bist.sv
// tb_cell3_bist: directed checks of two BIST instances (OR3 table, SETTLE=10; AND3 table, SETTLE=1).
module tb_cell3_bist;
    logic       CK = 1'b0;
    logic       rn = 1'b0;
    logic       st = 1'b0;
    logic       sel = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] a0, a1;
    logic       b0, d0, p0, b1, d1, p1, z0, z1;
    logic [3:0] e0, e1;
    logic [7:0] f0, f1;
    logic [17:0] o0, o1, o;
    int errs = 0;
    int checks = 0;

    always #5 CK = ~CK;

    // mode: 0 OR3, 1 tied 0, 2 tied 1, 3 AND3
    function automatic logic zf(input logic [1:0] m, input logic [2:0] a);
        return (m == 2'd0) ? |a : (m == 2'd1) ? 1'b0 : (m == 2'd2) ? 1'b1 : &a;
    endfunction

    assign z0 = zf(mode, a0);
    assign z1 = zf(mode, a1);
    assign o0 = {a0, b0, d0, p0, e0, f0};
    assign o1 = {a1, b1, d1, p1, e1, f1};
    assign o  = sel ? o1 : o0;

    cell3_bist u0 (.CK(CK), .RN(rn), .start(st & ~sel), .ZN(z0), .A1(a0[2]), .A2(a0[1]), .A3(a0[0]),
                   .busy(b0), .done(d0), .pass(p0), .err_cnt(e0), .fail_vec(f0));
    cell3_bist #(.SETTLE(1), .TT(8'h80)) u1 (.CK(CK), .RN(rn), .start(st & sel), .ZN(z1),
                   .A1(a1[2]), .A2(a1[1]), .A3(a1[0]), .busy(b1), .done(d1), .pass(p1),
                   .err_cnt(e1), .fail_vec(f1));

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Start a pass on the selected instance and check A/busy/done after every edge up to done.
    task automatic run(input bit hold, input string tag);
        int s, n, bad;
        logic [4:0] ex;
        s = sel ? 1 : 10;
        n = 8 * (s + 2);
        bad = 0;
        @(negedge CK);
        st = 1'b1;
        @(posedge CK);
        #1;
        st = hold;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge CK);
                #1;
            end
            ex = (k < n) ? {3'(k / (s + 2)), 2'b10} : 5'b00001;
            if (o[17:13] !== ex) begin
                if (bad == 0) $display("FAIL %s seq at edge %0d: got %0h expected %0h", tag, k, o[17:13], ex);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errs++;
    endtask

    typedef struct {
        bit         s;
        logic [1:0] m;
        int         err;
        int         fail;
        int         pass;
    } vec_t;
    vec_t tv[7];

    initial begin
        tv[0] = '{1'b0, 2'd0, 0, 8'h00, 1};
        tv[1] = '{1'b0, 2'd1, 7, 8'hFE, 0};
        tv[2] = '{1'b0, 2'd2, 1, 8'h01, 0};
        tv[3] = '{1'b0, 2'd3, 6, 8'h7E, 0};
        tv[4] = '{1'b1, 2'd3, 0, 8'h00, 1};
        tv[5] = '{1'b1, 2'd0, 6, 8'h7E, 0};
        tv[6] = '{1'b1, 2'd1, 1, 8'h80, 0};

        st = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        chk("reset u0", int'(o0), 0);
        chk("reset u1", int'(o1), 0);
        st = 1'b0;
        rn = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        chk("idle u0", int'(o0), 0);

        for (int i = 0; i < 7; i++) begin
            sel  = tv[i].s;
            mode = tv[i].m;
            run(1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d err", i), int'(o[11:8]), tv[i].err);
            chk($sformatf("vec%0d fail", i), int'(o[7:0]), tv[i].fail);
            chk($sformatf("vec%0d pass", i), int'(o[12]), tv[i].pass);
            repeat (3) @(posedge CK);
            #1;
            chk($sformatf("vec%0d hold", i), int'({o[13], o[11:0]}), (1 << 12) | (tv[i].err << 8) | tv[i].fail);
        end

        sel  = 1'b0;
        mode = 2'd1;
        run(1'b1, "hold");
        chk("hold err", int'(o[11:8]), 7);
        chk("hold fail", int'(o[7:0]), 8'hFE);
        @(posedge CK);
        #1;
        st = 1'b0;
        chk("restart", int'(o), 18'b000_1_0_0_0000_00000000);
        mode = 2'd0;
        for (int i = 0; i < 200 && !o[13]; i++) begin
            @(posedge CK);
            #1;
        end
        chk("restart done", int'(o[13:8]), 6'b110000);

        @(negedge CK);
        st = 1'b1;
        @(posedge CK);
        #1;
        st = 1'b0;
        repeat (40) @(posedge CK);
        #1;
        chk("mid pass", int'(o[17:13]), 5'b011_1_0);
        @(negedge CK);
        rn = 1'b0;
        @(posedge CK);
        #1;
        rn = 1'b1;
        chk("abort reset", int'(o0), 0);
        run(1'b0, "rerun");
        chk("rerun result", int'(o[12:0]), 13'h1000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cell3_bist.md
CELL3_BIST -- requirements
Module: cell3_bist

Interface
REQ-001 The block SHALL have parameter SETTLE, default 10, giving the number of wait cycles between applying a pattern and sampling the response; legal range 1..255.
REQ-002 The block SHALL have parameter TT, 8 bits, default 8'hFE, giving the expected truth table; TT[i] is the expected ZN for pattern i = {A1,A2,A3}; the default encodes OR3.
REQ-003 Port CK, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-004 Port RN, input, 1 bit, reset; synchronous and active-low.
REQ-005 Port start, input, 1 bit, a request to run a test pass; it is sampled only in IDLE or DONE.
REQ-006 Port ZN, input, 1 bit, the response of the 3-input cell under test.
REQ-007 Ports A1, A2, A3, output, 1 bit each, registered drive to the cell under test; A1 is the MSB of the pattern index.
REQ-008 Port busy, output, 1 bit, high while a test pass is in progress.
REQ-009 Port done, output, 1 bit, high while in DONE.
REQ-010 Port pass, output, 1 bit, high only when done=1 and err_cnt=0.
REQ-011 Port err_cnt, output, 4 bits, the mismatch count for the current or last pass, in the range 0..8.
REQ-012 Port fail_vec, output, 8 bits; bit i is set when pattern i mismatched.

Function
REQ-013 The FSM SHALL have the states IDLE, APPLY, WAIT, SAMPLE and DONE, and a 3-bit pattern index idx.
REQ-014 IDLE: the A outputs SHALL be 000 and busy=0; when start=1, the block SHALL set idx=0, clear err_cnt and fail_vec, drive A=000, and go to APPLY.
REQ-015 APPLY, one cycle: the block SHALL load the settle counter with SETTLE-1 and go to WAIT; the A outputs hold {idx}.
REQ-016 WAIT: the block SHALL decrement the counter each cycle and go to SAMPLE on the edge where the counter equals 0, so WAIT lasts exactly SETTLE cycles.
REQ-017 SAMPLE, one cycle: the block SHALL compare ZN against TT[idx]; on a mismatch it sets fail_vec[idx] and increments err_cnt.
REQ-018 SAMPLE exit when idx<7: the block SHALL increment idx, drive A={idx+1}, and go to APPLY.
REQ-019 SAMPLE exit when idx=7: the block SHALL go to DONE and SHALL NOT wrap idx.
REQ-020 Each pattern SHALL occupy exactly SETTLE+2 cycles, and the A outputs SHALL be stable for the whole APPLY, WAIT and SAMPLE period of that pattern.
REQ-021 Timing: if start is sampled at edge 0, done SHALL rise after edge 8*(SETTLE+2); for the default SETTLE this is edge 96.
REQ-022 busy SHALL be 1 in APPLY, WAIT and SAMPLE, and 0 in IDLE and DONE.
REQ-023 start while busy SHALL be ignored, with no restart and no effect on results.
REQ-024 DONE: the block SHALL hold done=1, err_cnt, fail_vec and pass, and drive A=000.
REQ-025 start=1 in DONE SHALL behave as in IDLE: results are cleared and the pass restarts at pattern 0 on the same edge.
REQ-026 In simulation, a ZN of X or Z at SAMPLE SHALL count as a mismatch.
REQ-027 err_cnt SHALL NOT saturate or wrap, because its maximum of 8 fits in 4 bits.

Reset
REQ-028 While RN=0 at a rising CK edge, the block SHALL set state=IDLE, idx=0, counter=0, A1=A2=A3=0, busy=0, done=0, pass=0, err_cnt=0 and fail_vec=0.
REQ-029 Reset SHALL take priority over start and over every state transition, including mid-pass; the partial results of an aborted pass SHALL be discarded.
REQ-030 No output SHALL change between clock edges; all outputs SHALL be registered.

Verification
REQ-031 TT=FE, SETTLE=10, ZN from a behavioural OR3, one-cycle start pulse -> A steps 000,001,...,111 with each held 12 cycles; done=1 after edge 96; pass=1, err_cnt=0, fail_vec=00.
REQ-032 Same setup with ZN tied 0 -> err_cnt=7, fail_vec=FE, pass=0, done=1 after edge 96.
REQ-033 Same setup with ZN tied 1 -> err_cnt=1, fail_vec=01, pass=0.
REQ-034 RN pulled low for one edge while idx=3 in WAIT -> the next cycle shows all outputs at their reset values; a new start yields a clean pass of 96 cycles with the OR3 model.
REQ-035 start held high for the whole pass -> the run is not restarted and done rises at edge 96; start=1 in DONE -> fail_vec and err_cnt clear and A=000 the next cycle, and the pass repeats.
REQ-036 TT=80, SETTLE=1, ZN from a behavioural AND3 -> done after edge 24, pass=1; the same run with an OR3 model -> err_cnt=6, fail_vec=7E.
